// File: rtl/game_controller.sv
// Breakout game sequencer: one registered state machine that turns the frame
// pulse, start/pause controls, lava event and block flags into the ball move
// strobes, serve hold, block reload pulse, lives, speed level and game status.
module game_controller #(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned OVER_FRAMES  = 120,
    parameter int unsigned N_BLOCKS     = 5,
    parameter int unsigned SPEED_MAX    = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                frame_start,
    input  logic                start,
    input  logic                pause,
    input  logic                endgame_ball,
    input  logic [N_BLOCKS-1:0] block_exist,
    output logic                move_tick,
    output logic                ball_serve,
    output logic                blocks_reload,
    output logic [1:0]          lives,
    output logic [2:0]          speed,
    output logic [2:0]          state,
    output logic                game_over,
    output logic                game_won
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_LOST  = 3'd4,
        ST_OVER  = 3'd5,
        ST_WON   = 3'd6
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
    localparam logic [7:0] OVER_LOAD  = 8'(OVER_FRAMES);
    localparam logic [2:0] SPEED_TOP  = 3'(SPEED_MAX);

    state_t      state_r, state_next_s;
    logic [1:0]  lives_r, lives_next_s;
    logic [2:0]  speed_r, speed_next_s;
    logic [7:0]  frame_cnt_r, frame_cnt_next_s;
    logic [2:0]  burst_cnt_r, burst_next_s, burst_src_s;
    logic [1:0]  guard_r, guard_next_s;
    logic        start_q_r;
    logic        move_tick_r, tick_next_s;
    logic        ball_serve_r, blocks_reload_r, game_over_r, game_won_r;
    logic        reload_s;
    logic        start_rise_s;
    logic        all_clear_s;

    assign start_rise_s = start & ~start_q_r;
    // Stale zeros right after a reload must not count as a cleared wall.
    assign all_clear_s  = (block_exist == {N_BLOCKS{1'b0}}) && (guard_r == 2'd0);

    // Next-state, lives, speed and frame counter decisions.
    always_comb begin
        state_next_s     = state_r;
        lives_next_s     = lives_r;
        speed_next_s     = speed_r;
        frame_cnt_next_s = frame_cnt_r;
        reload_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_rise_s) begin
                    state_next_s     = ST_SERVE;
                    lives_next_s     = LIVES_INIT;
                    speed_next_s     = 3'd1;
                    frame_cnt_next_s = SERVE_LOAD;
                    reload_s         = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (frame_start) begin
                    if (frame_cnt_r <= 8'd1) begin
                        state_next_s     = ST_PLAY;
                        frame_cnt_next_s = 8'd0;
                    end else begin
                        frame_cnt_next_s = frame_cnt_r - 8'd1;
                    end
                end else begin
                    state_next_s = ST_SERVE;
                end
            end
            ST_PLAY: begin
                if (all_clear_s) begin
                    state_next_s = ST_WON;
                end else if (endgame_ball) begin
                    state_next_s = ST_LOST;
                    lives_next_s = (lives_r != 2'd0) ? (lives_r - 2'd1) : 2'd0;
                end else if (pause) begin
                    state_next_s = ST_PAUSE;
                end else begin
                    state_next_s = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                if (!pause) begin
                    state_next_s = ST_PLAY;
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            ST_LOST: begin
                if (lives_r == 2'd0) begin
                    state_next_s     = ST_OVER;
                    frame_cnt_next_s = OVER_LOAD;
                end else begin
                    state_next_s     = ST_SERVE;
                    frame_cnt_next_s = SERVE_LOAD;
                end
            end
            ST_OVER: begin
                if (start_rise_s) begin
                    state_next_s = ST_IDLE;
                end else if (frame_start) begin
                    if (frame_cnt_r <= 8'd1) begin
                        state_next_s     = ST_IDLE;
                        frame_cnt_next_s = 8'd0;
                    end else begin
                        frame_cnt_next_s = frame_cnt_r - 8'd1;
                    end
                end else begin
                    state_next_s = ST_OVER;
                end
            end
            ST_WON: begin
                if (speed_r < SPEED_TOP) begin
                    state_next_s     = ST_SERVE;
                    speed_next_s     = speed_r + 3'd1;
                    frame_cnt_next_s = SERVE_LOAD;
                    reload_s         = 1'b1;
                end else if (start_rise_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WON;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Move burst: a frame pulse in PLAY reloads the burst, leaving PLAY kills it.
    always_comb begin
        burst_src_s  = frame_start ? speed_r : burst_cnt_r;
        burst_next_s = 3'd0;
        tick_next_s  = 1'b0;
        if ((state_r == ST_PLAY) && (state_next_s == ST_PLAY) && (burst_src_s != 3'd0)) begin
            tick_next_s  = 1'b1;
            burst_next_s = burst_src_s - 3'd1;
        end else begin
            tick_next_s  = 1'b0;
            burst_next_s = 3'd0;
        end
    end

    // Block-flag blanking window after each reload pulse.
    always_comb begin
        if (reload_s) begin
            guard_next_s = 2'd2;
        end else if (guard_r != 2'd0) begin
            guard_next_s = guard_r - 2'd1;
        end else begin
            guard_next_s = 2'd0;
        end
    end

    // State and output registers; Moore outputs are decoded from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            lives_r         <= 2'd0;
            speed_r         <= 3'd1;
            frame_cnt_r     <= 8'd0;
            burst_cnt_r     <= 3'd0;
            guard_r         <= 2'd0;
            start_q_r       <= 1'b1;
            move_tick_r     <= 1'b0;
            ball_serve_r    <= 1'b0;
            blocks_reload_r <= 1'b0;
            game_over_r     <= 1'b0;
            game_won_r      <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            lives_r         <= lives_next_s;
            speed_r         <= speed_next_s;
            frame_cnt_r     <= frame_cnt_next_s;
            burst_cnt_r     <= burst_next_s;
            guard_r         <= guard_next_s;
            start_q_r       <= start;
            move_tick_r     <= tick_next_s;
            ball_serve_r    <= (state_next_s == ST_SERVE);
            blocks_reload_r <= reload_s;
            game_over_r     <= (state_next_s == ST_OVER);
            game_won_r      <= (state_next_s == ST_WON) && (speed_next_s == SPEED_TOP);
        end
    end

    assign state         = state_r;
    assign lives         = lives_r;
    assign speed         = speed_r;
    assign move_tick     = move_tick_r;
    assign ball_serve    = ball_serve_r;
    assign blocks_reload = blocks_reload_r;
    assign game_over     = game_over_r;
    assign game_won      = game_won_r;

endmodule
